// File: rtl/airlock_pkg.sv
// Shared encodings for the airlock sequencer: states, error codes,
// trip directions and the port-fault classifier.
package airlock_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'h0,
    ST_PREP        = 4'h1,
    ST_WAIT_FILL   = 4'h2,
    ST_FILLING     = 4'h3,
    ST_WAIT_DRAIN  = 4'h4,
    ST_DRAINING    = 4'h5,
    ST_OPEN_OUTER  = 4'h6,
    ST_CLOSE_OUTER = 4'h7,
    ST_OPEN_INNER  = 4'h8,
    ST_CLOSE_INNER = 4'h9,
    ST_ERROR       = 4'hA
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BOTH  = 2'd1;
  localparam logic [1:0] ERR_OPORT = 2'd2;
  localparam logic [1:0] ERR_IPORT = 2'd3;

  localparam logic DIR_ARRIVE = 1'b0;
  localparam logic DIR_DEPART = 1'b1;

  // States whose exit is governed by the dwell timer.
  function automatic logic is_timed(input state_t s);
    return (s == ST_PREP) || (s == ST_FILLING) || (s == ST_DRAINING);
  endfunction

  // Classify port activity against the current state; the order of the
  // tests encodes the fault priority (both open beats a single bad port).
  function automatic logic [1:0] port_fault(input state_t s,
                                            input logic   iport,
                                            input logic   oport);
    logic outer_window;
    logic inner_window;
    outer_window = (s == ST_OPEN_OUTER) || (s == ST_CLOSE_OUTER);
    inner_window = (s == ST_OPEN_INNER) || (s == ST_CLOSE_INNER);
    if (iport && oport)
      return ERR_BOTH;
    else if (oport && !outer_window)
      return ERR_OPORT;
    else if (iport && !inner_window)
      return ERR_IPORT;
    else
      return ERR_NONE;
  endfunction

endpackage

// File: rtl/airlock_sequencer_if.sv
// Request/sensor inputs and status outputs of the airlock sequencer.
interface airlock_if;
  logic       arrive;
  logic       depart;
  logic       fill;
  logic       drain;
  logic       iport;
  logic       oport;
  logic [3:0] state;
  logic       dir;
  logic       chamber_hi;
  logic       fill_valve;
  logic       drain_valve;
  logic       iport_ok;
  logic       oport_ok;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  // Side that issues requests and reads status (board wrapper / bench).
  modport master (
    output arrive, depart, fill, drain, iport, oport,
    input  state, dir, chamber_hi, fill_valve, drain_valve,
    input  iport_ok, oport_ok, busy, err, err_code
  );

  // Side implemented by the sequencer.
  modport slave (
    input  arrive, depart, fill, drain, iport, oport,
    output state, dir, chamber_hi, fill_valve, drain_valve,
    output iport_ok, oport_ok, busy, err, err_code
  );
endinterface

// File: rtl/airlock_sequencer_dwell_timer.sv
// Dwell counter: restarts from zero on clear, counts while enabled and
// flags the cycle on which the count equals the programmed limit.
module dwell_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Count register; clear wins over increment so a new phase starts at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + CNT_W'(1);
  end

  // Last cycle of the phase: the owner leaves the state on the next edge.
  always_comb begin
    done = enable && (count == limit);
  end

endmodule

// File: rtl/airlock_sequencer.sv
// Bidirectional lock-chamber sequencer: serves arrivals and departures,
// tracks chamber level across trips and latches illegal port activity.
import airlock_pkg::*;

module airlock_sequencer #(
  parameter int CNT_W           = 27,
  parameter int PREP_CYCLES     = 2**25,
  parameter int FILL_CYCLES     = 2**25,
  parameter int DRAIN_CYCLES    = 2**25,
  parameter bit ARRIVE_PRIORITY = 1'b1
) (
  input logic      clock,
  input logic      reset,
  airlock_if.slave bus
);

  localparam logic [CNT_W-1:0] PREP_LIM  = CNT_W'(PREP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LIM  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             chamber_hi_q, chamber_hi_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [1:0]       fault;
  logic             timer_clear;
  logic             timer_en;
  logic             timer_done;
  logic [CNT_W-1:0] timer_limit;

  logic             fill_valve_q, drain_valve_q;
  logic             iport_ok_q, oport_ok_q;
  logic             busy_q, err_q;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  // Timer control: any state change restarts the count, so every timed
  // state begins at zero and lasts exactly its programmed number of cycles.
  always_comb begin
    timer_clear = (state_d != state_q);
    timer_en    = is_timed(state_q);
    timer_limit = '0;
    case (state_q)
      ST_PREP:     timer_limit = PREP_LIM;
      ST_FILLING:  timer_limit = FILL_LIM;
      ST_DRAINING: timer_limit = DRAIN_LIM;
      default:     timer_limit = '0;
    endcase
  end

  // Port fault classification for the current state.
  always_comb begin
    fault = port_fault(state_q, bus.iport, bus.oport);
  end

  // Next-state logic; a detected fault overrides every trip transition.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    chamber_hi_d = chamber_hi_q;
    err_code_d   = err_code_q;
    if ((state_q != ST_ERROR) && (fault != ERR_NONE)) begin
      state_d    = ST_ERROR;
      err_code_d = fault;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.arrive && bus.depart) begin
            dir_d   = ARRIVE_PRIORITY ? DIR_ARRIVE : DIR_DEPART;
            state_d = ST_PREP;
          end else if (bus.arrive) begin
            dir_d   = DIR_ARRIVE;
            state_d = ST_PREP;
          end else if (bus.depart) begin
            dir_d   = DIR_DEPART;
            state_d = ST_PREP;
          end
        end
        ST_PREP: begin
          if (timer_done) begin
            if (dir_q == DIR_ARRIVE)
              state_d = chamber_hi_q ? ST_OPEN_OUTER : ST_WAIT_FILL;
            else
              state_d = chamber_hi_q ? ST_WAIT_DRAIN : ST_OPEN_INNER;
          end
        end
        ST_WAIT_FILL: begin
          if (bus.fill)
            state_d = ST_FILLING;
        end
        ST_FILLING: begin
          if (timer_done) begin
            chamber_hi_d = 1'b1;
            state_d      = ST_OPEN_OUTER;
          end
        end
        ST_WAIT_DRAIN: begin
          if (bus.drain)
            state_d = ST_DRAINING;
        end
        ST_DRAINING: begin
          if (timer_done) begin
            chamber_hi_d = 1'b0;
            state_d      = ST_OPEN_INNER;
          end
        end
        ST_OPEN_OUTER: begin
          if (bus.oport)
            state_d = ST_CLOSE_OUTER;
        end
        ST_CLOSE_OUTER: begin
          if (!bus.oport)
            state_d = (dir_q == DIR_ARRIVE) ? ST_WAIT_DRAIN : ST_IDLE;
        end
        ST_OPEN_INNER: begin
          if (bus.iport)
            state_d = ST_CLOSE_INNER;
        end
        ST_CLOSE_INNER: begin
          if (!bus.iport)
            state_d = (dir_q == DIR_ARRIVE) ? ST_IDLE : ST_WAIT_FILL;
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, trip direction, chamber level and first error code.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_ARRIVE;
      chamber_hi_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      chamber_hi_q <= chamber_hi_d;
      err_code_q   <= err_code_d;
    end
  end

  // Moore outputs decoded from the next state so they update on the same
  // edge as the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_valve_q  <= 1'b0;
      drain_valve_q <= 1'b0;
      iport_ok_q    <= 1'b0;
      oport_ok_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      fill_valve_q  <= (state_d == ST_FILLING);
      drain_valve_q <= (state_d == ST_DRAINING);
      iport_ok_q    <= (state_d == ST_OPEN_INNER) || (state_d == ST_CLOSE_INNER);
      oport_ok_q    <= (state_d == ST_OPEN_OUTER) || (state_d == ST_CLOSE_OUTER);
      busy_q        <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
      err_q         <= (state_d == ST_ERROR);
    end
  end

  // Drive the status side of the interface from registers only.
  always_comb begin
    bus.state       = state_q;
    bus.dir         = dir_q;
    bus.chamber_hi  = chamber_hi_q;
    bus.err_code    = err_code_q;
    bus.fill_valve  = fill_valve_q;
    bus.drain_valve = drain_valve_q;
    bus.iport_ok    = iport_ok_q;
    bus.oport_ok    = oport_ok_q;
    bus.busy        = busy_q;
    bus.err         = err_q;
  end

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer with PREP=3, FILL=5, DRAIN=4.
// A second instance with depart priority follows the same inputs.
import airlock_pkg::*;

module tb_airlock_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   compared;
  int   mismatched;
  int   n;

  airlock_if bus0 ();
  airlock_if bus1 ();

  assign bus1.arrive = bus0.arrive;
  assign bus1.depart = bus0.depart;
  assign bus1.fill   = bus0.fill;
  assign bus1.drain  = bus0.drain;
  assign bus1.iport  = bus0.iport;
  assign bus1.oport  = bus0.oport;

  airlock_sequencer #(
    .CNT_W (4), .PREP_CYCLES (3), .FILL_CYCLES (5), .DRAIN_CYCLES (4),
    .ARRIVE_PRIORITY (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  airlock_sequencer #(
    .CNT_W (4), .PREP_CYCLES (3), .FILL_CYCLES (5), .DRAIN_CYCLES (4),
    .ARRIVE_PRIORITY (1'b0)
  ) dut_dp (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive cycles with fill_valve high, starting on the entry cycle.
  task automatic fill_run(output int cnt);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus0.fill_valve) break;
      cnt++;
    end
  endtask

  task automatic drain_run(output int cnt);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus0.drain_valve) break;
      cnt++;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset       = 1'b0;
    bus0.arrive = 1'b0;
    bus0.depart = 1'b0;
    bus0.fill   = 1'b0;
    bus0.drain  = 1'b0;
    bus0.iport  = 1'b0;
    bus0.oport  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_state", 32'(bus0.state), 32'(ST_IDLE));
    check("rst_dir", 32'(bus0.dir), 32'd0);
    check("rst_chamber", 32'(bus0.chamber_hi), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_err", 32'(bus0.err), 32'd0);
    check("rst_err_code", 32'(bus0.err_code), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_hold", 32'(bus0.state), 32'(ST_IDLE));

    // Arrival, chamber low
    bus0.arrive = 1'b1;
    tick();
    bus0.arrive = 1'b0;
    check("arr_prep", 32'(bus0.state), 32'(ST_PREP));
    check("arr_busy", 32'(bus0.busy), 32'd1);
    check("arr_dir", 32'(bus0.dir), 32'd0);
    tick();
    tick();
    check("arr_prep_c3", 32'(bus0.state), 32'(ST_PREP));
    tick();
    check("arr_wait_fill", 32'(bus0.state), 32'(ST_WAIT_FILL));
    tick();
    check("arr_wait_fill_hold", 32'(bus0.state), 32'(ST_WAIT_FILL));
    bus0.fill = 1'b1;
    tick();
    bus0.fill = 1'b0;
    check("arr_filling", 32'(bus0.state), 32'(ST_FILLING));
    fill_run(n);
    check("arr_fill_len", 32'(n), 32'd5);
    check("arr_open_outer", 32'(bus0.state), 32'(ST_OPEN_OUTER));
    check("arr_chamber_hi", 32'(bus0.chamber_hi), 32'd1);
    check("arr_oport_ok", 32'(bus0.oport_ok), 32'd1);
    bus0.oport = 1'b1;
    tick();
    check("arr_close_outer", 32'(bus0.state), 32'(ST_CLOSE_OUTER));
    bus0.oport = 1'b0;
    tick();
    check("arr_wait_drain", 32'(bus0.state), 32'(ST_WAIT_DRAIN));
    bus0.drain = 1'b1;
    tick();
    bus0.drain = 1'b0;
    check("arr_draining", 32'(bus0.state), 32'(ST_DRAINING));
    drain_run(n);
    check("arr_drain_len", 32'(n), 32'd4);
    check("arr_open_inner", 32'(bus0.state), 32'(ST_OPEN_INNER));
    check("arr_chamber_lo", 32'(bus0.chamber_hi), 32'd0);
    check("arr_iport_ok", 32'(bus0.iport_ok), 32'd1);
    bus0.iport = 1'b1;
    tick();
    check("arr_close_inner", 32'(bus0.state), 32'(ST_CLOSE_INNER));
    bus0.iport = 1'b0;
    tick();
    check("arr_end_idle", 32'(bus0.state), 32'(ST_IDLE));
    check("arr_end_busy", 32'(bus0.busy), 32'd0);

    // Departure, chamber low
    bus0.depart = 1'b1;
    tick();
    bus0.depart = 1'b0;
    check("dep_prep", 32'(bus0.state), 32'(ST_PREP));
    check("dep_dir", 32'(bus0.dir), 32'd1);
    repeat (3) tick();
    check("dep_open_inner", 32'(bus0.state), 32'(ST_OPEN_INNER));
    bus0.iport = 1'b1;
    tick();
    bus0.iport = 1'b0;
    tick();
    check("dep_wait_fill", 32'(bus0.state), 32'(ST_WAIT_FILL));
    bus0.fill = 1'b1;
    tick();
    bus0.fill = 1'b0;
    fill_run(n);
    check("dep_fill_len", 32'(n), 32'd5);
    check("dep_open_outer", 32'(bus0.state), 32'(ST_OPEN_OUTER));
    bus0.oport = 1'b1;
    tick();
    bus0.oport = 1'b0;
    tick();
    check("dep_end_idle", 32'(bus0.state), 32'(ST_IDLE));
    check("dep_chamber_hi", 32'(bus0.chamber_hi), 32'd1);

    // Arrival with chamber already high skips filling
    bus0.arrive = 1'b1;
    tick();
    bus0.arrive = 1'b0;
    repeat (2) tick();
    check("hi_prep_last", 32'(bus0.state), 32'(ST_PREP));
    tick();
    check("hi_open_outer", 32'(bus0.state), 32'(ST_OPEN_OUTER));
    check("hi_no_fill", 32'(bus0.fill_valve), 32'd0);
    bus0.oport = 1'b1;
    tick();
    bus0.oport = 1'b0;
    tick();
    bus0.drain = 1'b1;
    tick();
    bus0.drain = 1'b0;
    drain_run(n);
    check("hi_drain_len", 32'(n), 32'd4);
    bus0.iport = 1'b1;
    tick();
    bus0.iport = 1'b0;
    tick();
    check("hi_end_idle", 32'(bus0.state), 32'(ST_IDLE));
    check("hi_chamber_lo", 32'(bus0.chamber_hi), 32'd0);

    // Simultaneous request: priority decides direction
    bus0.arrive = 1'b1;
    bus0.depart = 1'b1;
    tick();
    bus0.arrive = 1'b0;
    bus0.depart = 1'b0;
    check("sim_state", 32'(bus0.state), 32'(ST_PREP));
    check("sim_dir_arrive_pri", 32'(bus0.dir), 32'd0);
    check("sim_dir_depart_pri", 32'(bus1.dir), 32'd1);
    repeat (3) tick();
    check("sim_arr_route", 32'(bus0.state), 32'(ST_WAIT_FILL));
    check("sim_dep_route", 32'(bus1.state), 32'(ST_OPEN_INNER));
    pulse_reset();
    check("sim_reset_idle", 32'(bus1.state), 32'(ST_IDLE));

    // Illegal oport during filling
    bus0.arrive = 1'b1;
    tick();
    bus0.arrive = 1'b0;
    repeat (3) tick();
    bus0.fill = 1'b1;
    tick();
    bus0.fill = 1'b0;
    tick();
    check("ill_filling", 32'(bus0.fill_valve), 32'd1);
    bus0.oport = 1'b1;
    tick();
    check("ill_state", 32'(bus0.state), 32'(ST_ERROR));
    check("ill_err", 32'(bus0.err), 32'd1);
    check("ill_code2", 32'(bus0.err_code), 32'd2);
    check("ill_fill_off", 32'(bus0.fill_valve), 32'd0);
    check("ill_busy", 32'(bus0.busy), 32'd0);
    bus0.iport = 1'b1;
    bus0.arrive = 1'b1;
    bus0.drain = 1'b1;
    tick();
    bus0.oport = 1'b0;
    bus0.iport = 1'b0;
    bus0.depart = 1'b1;
    bus0.fill = 1'b1;
    repeat (3) tick();
    bus0.arrive = 1'b0;
    bus0.depart = 1'b0;
    bus0.fill = 1'b0;
    bus0.drain = 1'b0;
    tick();
    check("ill_sticky", 32'(bus0.state), 32'(ST_ERROR));
    check("ill_code_held", 32'(bus0.err_code), 32'd2);
    pulse_reset();
    check("ill_reset_idle", 32'(bus0.state), 32'(ST_IDLE));
    check("ill_reset_code", 32'(bus0.err_code), 32'd0);

    // Both ports open
    bus0.iport = 1'b1;
    bus0.oport = 1'b1;
    tick();
    bus0.iport = 1'b0;
    bus0.oport = 1'b0;
    check("both_state", 32'(bus0.state), 32'(ST_ERROR));
    check("both_code1", 32'(bus0.err_code), 32'd1);
    pulse_reset();

    // Inner port opened while idle
    bus0.iport = 1'b1;
    tick();
    bus0.iport = 1'b0;
    check("iport_code3", 32'(bus0.err_code), 32'd3);
    pulse_reset();

    // Reset during draining at count 2
    bus0.arrive = 1'b1;
    tick();
    bus0.arrive = 1'b0;
    repeat (3) tick();
    bus0.fill = 1'b1;
    tick();
    bus0.fill = 1'b0;
    fill_run(n);
    bus0.oport = 1'b1;
    tick();
    bus0.oport = 1'b0;
    tick();
    bus0.drain = 1'b1;
    tick();
    bus0.drain = 1'b0;
    check("mid_draining", 32'(bus0.state), 32'(ST_DRAINING));
    repeat (2) tick();
    check("mid_still_draining", 32'(bus0.drain_valve), 32'd1);
    reset = 1'b0;
    #2;
    check("mid_async_idle", 32'(bus0.state), 32'(ST_IDLE));
    check("mid_chamber_lo", 32'(bus0.chamber_hi), 32'd0);
    check("mid_drain_off", 32'(bus0.drain_valve), 32'd0);
    check("mid_busy_off", 32'(bus0.busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    bus0.arrive = 1'b1;
    tick();
    bus0.arrive = 1'b0;
    check("restart_prep", 32'(bus0.state), 32'(ST_PREP));
    repeat (3) tick();
    check("restart_wait_fill", 32'(bus0.state), 32'(ST_WAIT_FILL));
    bus0.fill = 1'b1;
    tick();
    bus0.fill = 1'b0;
    fill_run(n);
    check("restart_fill_len", 32'(n), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
